// File: rtl/instr_stream_encoder_if.sv
// Field-bundle stream into the encoder plus the instruction-memory write bus and load status.
// slave = encoder side, master = producer / memory side.
interface instr_stream_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              err;
    logic              core_release;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata, word_count, err, core_release
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata, word_count, err, core_release
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs symbolic instruction fields into 32-bit words and loads them into instruction memory.
// Latency: one cycle from acceptance to the mem_we pulse.
// Backpressure: in_ready only in LOAD and never in a start cycle; independent of in_valid.
module instr_stream_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instr_stream_encoder_if.slave  bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] fun;
    } r_word_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_word_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              we_q;
    logic              err_q;

    logic              accept;
    logic              legal;
    logic [31:0]       enc_word;
    r_word_t           r_word;
    i_word_t           i_word;

    assign bus.in_ready = (state_q == LOAD) && !start;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        legal        = 1'b0;
        enc_word     = '0;
        r_word       = '{opcode: 6'b110000, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                         shamt: bus.in_shamt, fun: {1'b0, bus.in_op}};
        i_word       = '{opcode: {3'b100, bus.in_op[2:0]}, rs: bus.in_rs, rt: bus.in_rt,
                         imm: bus.in_imm};
        if (bus.in_op <= 5'd13) begin
            legal    = 1'b1;
            enc_word = r_word;
        end else if (bus.in_op >= 5'd16 && bus.in_op <= 5'd23) begin
            // lw..slti are contiguous, so the low op bits select the I-type opcode directly
            legal    = 1'b1;
            enc_word = i_word;
        end else if (bus.in_op == 5'd24) begin
            legal    = 1'b1;
            enc_word = {6'b000000, bus.in_target};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = DONE;
                    end else if (legal && (ptr_q == {ADDR_W{1'b1}})) begin
                        state_d = FULL;
                    end
                end
            end
            default: state_d = state_q;
        endcase
        if (start) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= BASE;
            addr_q  <= BASE;
            wdata_q <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= accept && legal;
            if (start) begin
                ptr_q   <= BASE;
                addr_q  <= BASE;
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    addr_q  <= ptr_q;
                    wdata_q <= enc_word;
                    ptr_q   <= ptr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // A reset arriving while a write is registered suppresses that write
    assign bus.mem_we       = we_q && !rst;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.word_count   = count_q;
    assign bus.err          = err_q;
    assign bus.core_release = (state_q == DONE);
endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential instruction encoder and program loader for the processing-element core. It is the inverse of the core's decode stage. It accepts symbolic instruction fields over a valid/ready stream, packs them into 32-bit machine words using the core's opcode/function map, and writes them to consecutive instruction-memory addresses. When loading completes, it releases the core.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory address width, in words.
- BASE_ADDR, 0: first write address after each `start`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse; begins or restarts a load.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_op  in  5  mnemonic select:
  - 0–13: R-type, with fun = in_op (and, or, nor, xor, add, sub, mul, slt, sll, sgt, clo, rotr, sltu, sign).
  - 16–24: lw, sw, beq, bne, addi, andi, ori, slti, j.
  - Any other value is illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- in_last  in  1  marks the final bundle of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction word.
- word_count  out  ADDR_W+1  number of words written since `start`.
- err  out  1  sticky flag: an illegal in_op was accepted.
- core_release  out  1  high in DONE; drives the core's run enable.

## Operation
Encoding formats:
- R-type: opcode 110000 | rs[25:21] | rt[20:16] | rd[15:11] | shamt[10:6] | fun[5:0]. The upper two fun bits are 00.
- I-type: opcode | rs | rt | imm[15:0].
  - Opcodes: lw 100000, sw 100001, beq 100010, bne 100011, addi 100100, andi 100101, ori 100110, slti 100111.
- J-type: opcode 000000 | target[25:0].

State machine, with states IDLE, LOAD, FULL, DONE:
- IDLE: in_ready=0. `start` moves to LOAD.
- LOAD: in_ready = !start. A bundle is accepted when in_valid && in_ready.
  - Legal op: the word is registered and written on the next cycle.
  - Illegal op: the bundle is consumed, err is set, and nothing is written; word_count and the address do not advance.
  - An accepted bundle with in_last=1 moves to DONE, whether it was legal or illegal.
  - An accepted legal word going to address 2^ADDR_W−1 without in_last moves to FULL.
- FULL: in_ready=0, core_release=0. Only `start` or `rst` leaves this state.
- DONE: in_ready=0, core_release=1. `start` returns to LOAD.

`start` from any state:
- Sets the address to BASE_ADDR and clears word_count and err.
- Enters LOAD.
- No bundle is accepted in the `start` cycle.
- A write already registered from the previous cycle still completes.

Address arithmetic:
- The next address is mem_addr+1, modulo 2^ADDR_W. It is never written past the top; FULL blocks this.
- When BASE_ADDR≠0, FULL is reached at the top address. The space below BASE_ADDR is not used.

Reset values:
- State IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err=0, core_release=0.
- Reset mid-load discards any pending write.

## Timing
- Latency: acceptance edge N produces mem_we=1 during cycle N+1, for exactly one cycle, with mem_addr and mem_wdata stable.
- Throughput: one word per cycle while in_valid stays high in LOAD.
- word_count increments on the same edge that raises mem_we.
- core_release rises on the edge after the last bundle is accepted. The final write's mem_we is high in that same cycle, so the memory sees the write no later than the core starts.
- in_ready depends combinationally on state and `start` only, never on in_valid.

## Test plan
- Reset, then start, then accept add rs=1 rt=2 rd=3 (in_op=4) → the next cycle shows mem_we=1, mem_addr=0, mem_wdata=0xC0221804, word_count=1.
- Back-to-back bundles:
  - lw rs=29 rt=5 imm=0x0010 → 0x83A50010 at address 0.
  - beq rs=1 rt=2 imm=0xFFFF → 0x8822FFFF at address 1.
  - j target=0x40 with in_last → 0x00000040 at address 2.
  - Then DONE, core_release=1, word_count=3.
- in_op=15 accepted mid-stream → err=1, no mem_we pulse. The following legal word takes the next address with no gap; err stays set until `start`.
- ADDR_W=2, 4 legal words with no in_last → writes go to addresses 0–3, then FULL, in_ready=0, core_release=0. A 5th in_valid is held off. Pulsing `start` returns to LOAD at address 0 with word_count=0.
- Assert `start` in a cycle with in_valid=1 during LOAD → that bundle is not accepted. The prior registered write still appears. The next bundle goes to BASE_ADDR.
- Assert rst one cycle after an acceptance → no mem_we, and all outputs return to their reset values on the next edge.
